stack_lifo_p: RTL and testbench

Parametrised synchronous LIFO stack for the Fibonacci datapath. It replaces the fixed 64x512 stack with configurable data width and depth. It adds full/empty flags, an occupancy count, a registered output-valid strobe, and an atomic push+pop "exchange". Overflow and underflow are reported and blocked. The controller FSM uses it to hold pending recursion operands.

---
 rtl/stack_lifo_p.sv | 168 ++++++++++++++++
 tb/tb_stack_lifo_p.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/stack_lifo_p.sv
// ----------------------------------------------------------------------------
// stack_lifo_p
//
// Parametrised synchronous LIFO stack. Holds pending recursion operands for
// the Fibonacci controller. One command per cycle, no back-pressure.
//
// Handshake: there is no ready. A command (push / pop / top) is sampled on
// every rising edge with rst low. d_valid is a one-cycle strobe meaning
// "d_out was loaded by the preceding edge"; d_out holds its value otherwise.
// overflow / underflow are one-cycle strobes for rejected commands.
//
// Parameters
//   WIDTH  data word width (>= 1)
//   DEPTH  number of entries (>= 2, any integer)
//   CW     derived count width, $clog2(DEPTH+1)
//
// Ports
//   clk        clock, all state updates on rising edge
//   rst        synchronous active-high reset
//   push       write d_in onto the stack
//   pop        remove top entry and present it on d_out
//   top        present top entry on d_out without removing it
//   d_in       data to push
//   d_out      registered read data
//   d_valid    d_out updated by the preceding edge
//   is_empty   count == 0
//   is_full    count == DEPTH
//   count      current number of entries
//   overflow   push rejected because the stack was full
//   underflow  pop/top rejected because the stack was empty
// ----------------------------------------------------------------------------
module stack_lifo_p #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 512,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             top,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             d_valid,
    output logic             is_empty,
    output logic             is_full,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(DEPTH);

    // Storage is intentionally not reset.
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [CW-1:0]    r_ptr;
    logic [WIDTH-1:0] r_dout;
    logic             r_valid;
    logic             r_ovf;
    logic             r_unf;

    logic             w_empty;
    logic             w_full;
    logic [AW-1:0]    w_top_addr;
    logic [AW-1:0]    w_push_addr;

    logic [CW-1:0]    w_ptr_next;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_addr;
    logic             w_rd_load;
    logic [WIDTH-1:0] w_rd_data;
    logic             w_valid_next;
    logic             w_ovf_next;
    logic             w_unf_next;

    assign w_empty     = (r_ptr == '0);
    assign w_full      = (r_ptr == CW'(DEPTH));
    // Top-of-stack address; forced to 0 when empty so the unused read stays
    // inside the array.
    assign w_top_addr  = w_empty ? '0 : AW'(r_ptr - CW'(1));
    // Only used when not full, so the truncation is always < DEPTH.
    assign w_push_addr = AW'(r_ptr);

    // Command decode in priority order: rst, exchange, push, pop, top.
    always_comb begin
        w_ptr_next   = r_ptr;
        w_wr_en      = 1'b0;
        w_wr_addr    = w_push_addr;
        w_rd_load    = 1'b0;
        w_rd_data    = r_mem[w_top_addr];
        w_valid_next = 1'b0;
        w_ovf_next   = 1'b0;
        w_unf_next   = 1'b0;

        if (!rst) begin
            if (push && pop) begin
                // Exchange: old top goes out, d_in replaces it. On an empty
                // stack d_in passes straight through.
                w_rd_load    = 1'b1;
                w_valid_next = 1'b1;
                if (w_empty) begin
                    w_rd_data = d_in;
                end else begin
                    w_wr_en   = 1'b1;
                    w_wr_addr = w_top_addr;
                end
            end else if (push) begin
                if (w_full) begin
                    w_ovf_next = 1'b1;
                end else begin
                    w_wr_en    = 1'b1;
                    w_ptr_next = r_ptr + CW'(1);
                end
            end else if (pop) begin
                if (w_empty) begin
                    w_unf_next = 1'b1;
                end else begin
                    w_rd_load    = 1'b1;
                    w_valid_next = 1'b1;
                    w_ptr_next   = r_ptr - CW'(1);
                end
            end else if (top) begin
                if (w_empty) begin
                    w_unf_next = 1'b1;
                end else begin
                    w_rd_load    = 1'b1;
                    w_valid_next = 1'b1;
                end
            end
        end
    end

    // The read above samples the array before this edge's write, so an
    // exchange returns the old top.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= d_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr   <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_ptr   <= w_ptr_next;
            r_valid <= w_valid_next;
            r_ovf   <= w_ovf_next;
            r_unf   <= w_unf_next;
            if (w_rd_load) begin
                r_dout <= w_rd_data;
            end
        end
    end

    assign d_out     = r_dout;
    assign d_valid   = r_valid;
    assign overflow  = r_ovf;
    assign underflow = r_unf;
    assign count     = r_ptr;
    assign is_empty  = w_empty;
    assign is_full   = w_full;

endmodule

// File: tb/tb_stack_lifo_p.sv
// Bench for stack_lifo_p with WIDTH=16, DEPTH=4. The driver issues one
// command per cycle, runs a queue-based stack model and pushes the expected
// per-cycle status plus any expected read data; a monitor checks outputs
// 2 time units after each rising edge.
module tb_stack_lifo_p;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             v;
    logic             o;
    logic             u;
    logic [CW-1:0]    cnt;
    logic             emp;
    logic             full;
    logic [WIDTH-1:0] dout;
  } status_t;

  // clock / reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             push = 1'b0, pop = 1'b0, top = 1'b0;
  logic [WIDTH-1:0] d_in = '0;
  logic [WIDTH-1:0] d_out;
  logic             d_valid, is_empty, is_full, overflow, underflow;
  logic [CW-1:0]    count;

  stack_lifo_p #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .top(top),
    .d_in(d_in), .d_out(d_out), .d_valid(d_valid),
    .is_empty(is_empty), .is_full(is_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  // scoreboard
  logic [WIDTH-1:0] exp_q[$];
  status_t          st_q[$];
  int               checks = 0;
  int               errors = 0;

  // reference model state
  logic [WIDTH-1:0] model_stk[$];
  logic [WIDTH-1:0] model_dout = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: apply one command for one edge and record what must come out
  task automatic cycle(input logic r, input logic p, input logic q,
                       input logic t, input logic [WIDTH-1:0] d);
    status_t s;
    rst = r; push = p; pop = q; top = t; d_in = d;
    s = '0;
    if (r) begin
      model_stk.delete();
      model_dout = '0;
    end else if (p && q) begin
      if (model_stk.size() > 0) begin
        model_dout = model_stk[$];
        model_stk[model_stk.size() - 1] = d;
      end else begin
        model_dout = d;
      end
      s.v = 1'b1;
    end else if (p) begin
      if (model_stk.size() < DEPTH) model_stk.push_back(d);
      else s.o = 1'b1;
    end else if (q) begin
      if (model_stk.size() > 0) begin
        model_dout = model_stk.pop_back();
        s.v = 1'b1;
      end else s.u = 1'b1;
    end else if (t) begin
      if (model_stk.size() > 0) begin
        model_dout = model_stk[$];
        s.v = 1'b1;
      end else s.u = 1'b1;
    end
    s.cnt  = CW'(model_stk.size());
    s.emp  = (model_stk.size() == 0);
    s.full = (model_stk.size() == DEPTH);
    s.dout = model_dout;
    if (s.v) exp_q.push_back(model_dout);
    st_q.push_back(s);
    @(posedge clk);
    #4;
  endtask

  // monitor
  always @(posedge clk) begin
    status_t s;
    #2;
    if (st_q.size() > 0) begin
      s = st_q.pop_front();
      chk("d_valid", 32'(d_valid), 32'(s.v));
      chk("overflow", 32'(overflow), 32'(s.o));
      chk("underflow", 32'(underflow), 32'(s.u));
      chk("count", 32'(count), 32'(s.cnt));
      chk("is_empty", 32'(is_empty), 32'(s.emp));
      chk("is_full", 32'(is_full), 32'(s.full));
      chk("d_out_held", 32'(d_out), 32'(s.dout));
      if (d_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL read_data: unexpected d_valid with d_out %0h, none expected", d_out);
        end else begin
          chk("read_data", 32'(d_out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    // reset held 2 cycles with a push pending
    cycle(1, 1, 0, 0, 16'hFFFF);
    cycle(1, 1, 0, 0, 16'hFFFF);
    cycle(0, 0, 0, 0, 16'h0000);

    // LIFO order
    cycle(0, 1, 0, 0, 16'h0001);
    cycle(0, 1, 0, 0, 16'h0002);
    cycle(0, 1, 0, 0, 16'h0003);
    repeat (3) cycle(0, 0, 1, 0, 16'h0000);
    cycle(0, 0, 0, 0, 16'h0000);

    // full / overflow
    cycle(0, 1, 0, 0, 16'h00A1);
    cycle(0, 1, 0, 0, 16'h00A2);
    cycle(0, 1, 0, 0, 16'h00A3);
    cycle(0, 1, 0, 0, 16'h00A4);
    cycle(0, 1, 0, 0, 16'hBEEF);
    cycle(0, 0, 0, 0, 16'h0000);
    cycle(0, 0, 1, 0, 16'h0000);
    repeat (3) cycle(0, 0, 1, 0, 16'h0000);

    // empty / underflow
    cycle(0, 0, 1, 0, 16'h0000);
    cycle(0, 0, 0, 1, 16'h0000);
    cycle(0, 0, 0, 0, 16'h0000);

    // exchange
    cycle(0, 1, 0, 0, 16'h0011);
    cycle(0, 1, 1, 0, 16'h0022);
    cycle(0, 0, 0, 1, 16'h0000);
    cycle(0, 1, 0, 0, 16'h0044);
    cycle(0, 1, 0, 0, 16'h0055);
    cycle(0, 1, 0, 0, 16'h0066);
    cycle(0, 1, 1, 1, 16'h0077);   // exchange when full, top ignored
    cycle(0, 0, 0, 1, 16'h0000);
    repeat (4) cycle(0, 0, 1, 0, 16'h0000);
    cycle(0, 1, 1, 0, 16'h0033);   // exchange on empty: pass-through

    // mid-operation reset
    cycle(0, 1, 0, 0, 16'h0101);
    cycle(0, 1, 0, 0, 16'h0202);
    cycle(0, 1, 0, 0, 16'h0303);
    cycle(1, 0, 1, 0, 16'h0000);
    cycle(0, 0, 0, 1, 16'h0000);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic r, p, q, t;
      r = ($urandom_range(0, 49) == 0);
      p = ($urandom_range(0, 1) == 1);
      q = ($urandom_range(0, 2) == 0);
      t = ($urandom_range(0, 3) == 0);
      cycle(r, p, q, t, 16'($urandom_range(0, 65535)));
    end
    cycle(0, 0, 0, 0, 16'h0000);

    @(posedge clk);
    #4;
    chk("status_queue_drained", 32'(st_q.size()), 32'd0);
    chk("data_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
